// File: rtl/cache_pkg.sv
// Shared types and geometry for the 2-way, 8-set, 32-byte-line data cache controller.
package cache_pkg;
  localparam int TAG_W      = 24;
  localparam int IDX_W      = 3;
  localparam int OFF_W      = 5;
  localparam int LINE_BYTES = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2,
    WTHRU     = 2'd3
  } state_e;
endpackage

// File: rtl/cache_ctrl.sv
// Cache sequencing FSM: hit strobes, dirty-victim writeback, line fill and MRU write-through.
// Handshake: a CPU request (cpu_rd/cpu_wr + cpu_addr) is held stable until cpu_ready;
// memory requests stay high until the single-cycle mem_ack, then drop the next cycle.
module cache_ctrl
  import cache_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             cpu_rd,
  input  logic             cpu_wr,
  input  logic [31:0]      cpu_addr,
  output logic             cpu_ready,
  output logic             cpu_stall,
  input  logic             hit,
  input  logic             lru_valid,
  input  logic             lru_dirty,
  input  logic [TAG_W-1:0] lru_tag,
  output logic             addr_valid,
  output logic             update_lru,
  output logic             update_tag,
  output logic             update_cacheline,
  output logic             set_valid,
  output logic             clear_valid,
  output logic             set_dirty,
  output logic             clear_dirty,
  output logic             mem_line_rd,
  output logic             mem_line_wr,
  output logic             mem_word_wr,
  output logic [31:0]      mem_addr,
  input  logic             mem_ack,
  output logic [1:0]       dbg_state_o
);

  state_e state_q, state_d;
  logic   req;
  logic   hit_is_lru;

  assign req        = cpu_rd | cpu_wr;
  assign hit_is_lru = lru_valid & (lru_tag == cpu_addr[31:32-TAG_W]);

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d          = state_q;
    cpu_ready        = 1'b0;
    addr_valid       = 1'b0;
    update_lru       = 1'b0;
    update_tag       = 1'b0;
    update_cacheline = 1'b0;
    set_valid        = 1'b0;
    clear_valid      = 1'b0;
    set_dirty        = 1'b0;
    clear_dirty      = 1'b0;
    mem_line_rd      = 1'b0;
    mem_line_wr      = 1'b0;
    mem_word_wr      = 1'b0;
    mem_addr         = 32'h0;
    if (!RST) begin
      unique case (state_q)
        IDLE: begin
          if (req) begin
            if (hit) begin
              // A simultaneous rd+wr is treated as a write.
              if (!cpu_wr) begin
                update_lru = 1'b1;
                cpu_ready  = 1'b1;
              end else if (hit_is_lru) begin
                addr_valid = 1'b1;
                set_dirty  = 1'b1;
                update_lru = 1'b1;
                cpu_ready  = 1'b1;
              end else begin
                // Dirty can only be set on the LRU way, so an MRU write goes to memory too.
                addr_valid = 1'b1;
                update_lru = 1'b1;
                state_d    = WTHRU;
              end
            end else begin
              state_d = (lru_valid & lru_dirty) ? WRITEBACK : FILL;
            end
          end
        end
        WRITEBACK: begin
          mem_line_wr = 1'b1;
          mem_addr    = {lru_tag, cpu_addr[OFF_W+IDX_W-1:OFF_W], {OFF_W{1'b0}}};
          if (mem_ack) begin
            clear_dirty = 1'b1;
            clear_valid = 1'b1;
            state_d     = FILL;
          end
        end
        FILL: begin
          mem_line_rd = 1'b1;
          mem_addr    = {cpu_addr[31:OFF_W], {OFF_W{1'b0}}};
          if (mem_ack) begin
            update_cacheline = 1'b1;
            update_tag       = 1'b1;
            set_valid        = 1'b1;
            clear_dirty      = 1'b1;
            state_d          = IDLE;
          end
        end
        WTHRU: begin
          mem_word_wr = 1'b1;
          mem_addr    = cpu_addr;
          if (mem_ack) begin
            cpu_ready = 1'b1;
            state_d   = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign cpu_stall   = req & ~cpu_ready;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: datapath status is driven by hand per cycle and all
// strobes, mem_addr and the FSM state are compared against hand-computed vectors.
module tb_cache_ctrl;
  import cache_pkg::*;

  logic             CLK = 1'b0;
  logic             RST;
  logic             cpu_rd, cpu_wr;
  logic [31:0]      cpu_addr;
  logic             cpu_ready, cpu_stall;
  logic             hit, lru_valid, lru_dirty;
  logic [TAG_W-1:0] lru_tag;
  logic             addr_valid, update_lru, update_tag, update_cacheline;
  logic             set_valid, clear_valid, set_dirty, clear_dirty;
  logic             mem_line_rd, mem_line_wr, mem_word_wr;
  logic [31:0]      mem_addr;
  logic             mem_ack;
  logic [1:0]       dbg_state_o;

  int n_chk  = 0;
  int n_fail = 0;

  // Output bit masks for the packed strobe vector.
  localparam logic [12:0] R  = 13'h1000, S  = 13'h0800, AV = 13'h0400, UL = 13'h0200;
  localparam logic [12:0] UT = 13'h0100, UC = 13'h0080, SV = 13'h0040, CV = 13'h0020;
  localparam logic [12:0] SD = 13'h0010, CD = 13'h0008, LR = 13'h0004, LW = 13'h0002;
  localparam logic [12:0] WW = 13'h0001, NONE = 13'h0000;

  logic [12:0] outs;
  assign outs = {cpu_ready, cpu_stall, addr_valid, update_lru, update_tag, update_cacheline,
                 set_valid, clear_valid, set_dirty, clear_dirty, mem_line_rd, mem_line_wr,
                 mem_word_wr};

  cache_ctrl dut (
    .CLK(CLK), .RST(RST), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_ready(cpu_ready), .cpu_stall(cpu_stall), .hit(hit), .lru_valid(lru_valid),
    .lru_dirty(lru_dirty), .lru_tag(lru_tag), .addr_valid(addr_valid),
    .update_lru(update_lru), .update_tag(update_tag), .update_cacheline(update_cacheline),
    .set_valid(set_valid), .clear_valid(clear_valid), .set_dirty(set_dirty),
    .clear_dirty(clear_dirty), .mem_line_rd(mem_line_rd), .mem_line_wr(mem_line_wr),
    .mem_word_wr(mem_word_wr), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .dbg_state_o(dbg_state_o)
  );

  // Clock / reset
  always #5 CLK = ~CLK;

  // Scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic h, input logic lv, input logic ld,
                       input logic [TAG_W-1:0] lt, input logic ack);
    cpu_rd = rd; cpu_wr = wr; cpu_addr = addr;
    hit = h; lru_valid = lv; lru_dirty = ld; lru_tag = lt; mem_ack = ack;
    #1;
  endtask

  task automatic expect_cycle(input string tag, input state_e st, input logic [12:0] o,
                              input logic [31:0] ma);
    check({tag, ".state"}, {30'd0, dbg_state_o}, {30'd0, st});
    check({tag, ".outs"}, {19'd0, outs}, {19'd0, o});
    check({tag, ".mem_addr"}, mem_addr, ma);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1;
    drive(0, 0, 32'h0, 0, 0, 0, '0, 0);
    tick();
    expect_cycle("rst_idle", IDLE, NONE, 32'h0);
    drive(1, 0, 32'h100, 1, 1, 0, 24'h1, 0);
    expect_cycle("rst_req", IDLE, S, 32'h0);
    tick();
    RST = 1'b0;

    // Clean miss on 0x100, ack on third FILL cycle, then replay hit.
    drive(1, 0, 32'h100, 0, 0, 0, '0, 0);
    expect_cycle("m1_decide", IDLE, S, 32'h0);
    tick();
    expect_cycle("m1_fill1", FILL, S | LR, 32'h100);
    tick();
    expect_cycle("m1_fill2", FILL, S | LR, 32'h100);
    tick();
    drive(1, 0, 32'h100, 0, 0, 0, '0, 1);
    expect_cycle("m1_fill_ack", FILL, S | LR | UC | UT | SV | CD, 32'h100);
    tick();
    drive(1, 0, 32'h100, 1, 1, 0, 24'h1, 0);
    expect_cycle("m1_replay", IDLE, R | UL, 32'h0);
    tick();

    // Read hit 0x104.
    drive(1, 0, 32'h104, 1, 0, 0, 24'h0, 0);
    expect_cycle("rd_hit", IDLE, R | UL, 32'h0);
    tick();

    // Write hit on LRU way at 0x108.
    drive(0, 1, 32'h108, 1, 1, 0, 24'h1, 0);
    expect_cycle("wr_lru", IDLE, R | AV | SD | UL, 32'h0);
    tick();

    // Conflicting miss in set 0: dirty victim tag 1, 1-cycle writeback then fill.
    drive(1, 0, 32'h1100, 0, 1, 1, 24'h1, 0);
    expect_cycle("m2_decide", IDLE, S, 32'h0);
    tick();
    drive(1, 0, 32'h1100, 0, 1, 1, 24'h1, 1);
    expect_cycle("m2_wb_ack", WRITEBACK, S | LW | CD | CV, 32'h100);
    tick();
    drive(1, 0, 32'h1100, 0, 0, 0, 24'h1, 0);
    expect_cycle("m2_fill", FILL, S | LR, 32'h1100);
    tick();
    drive(1, 0, 32'h1100, 0, 0, 0, 24'h1, 1);
    expect_cycle("m2_fill_ack", FILL, S | LR | UC | UT | SV | CD, 32'h1100);
    tick();
    drive(1, 0, 32'h1100, 1, 1, 0, 24'h11, 0);
    expect_cycle("m2_replay", IDLE, R | UL, 32'h0);
    tick();

    // Write hit on MRU way at 0x110 -> word write-through.
    drive(0, 1, 32'h110, 1, 1, 0, 24'h22, 0);
    expect_cycle("wt_decide", IDLE, S | AV | UL, 32'h0);
    tick();
    expect_cycle("wt_wait", WTHRU, S | WW, 32'h110);
    tick();
    drive(0, 1, 32'h110, 1, 1, 0, 24'h22, 1);
    expect_cycle("wt_ack", WTHRU, R | WW, 32'h110);
    tick();
    drive(0, 0, 32'h0, 0, 0, 0, '0, 0);
    expect_cycle("wt_done", IDLE, NONE, 32'h0);
    tick();

    // Dirty miss interrupted by reset during WRITEBACK.
    drive(1, 0, 32'h2200, 0, 1, 1, 24'h5, 0);
    expect_cycle("m3_decide", IDLE, S, 32'h0);
    tick();
    expect_cycle("m3_wb", WRITEBACK, S | LW, 32'h500);
    RST = 1'b1;
    drive(1, 0, 32'h2200, 0, 1, 1, 24'h5, 1);
    expect_cycle("m3_rst", WRITEBACK, S, 32'h0);
    tick();
    RST = 1'b0;
    drive(0, 0, 32'h0, 0, 1, 1, 24'h5, 0);
    expect_cycle("m3_after_rst", IDLE, NONE, 32'h0);

    // rd+wr together on an LRU hit behaves as a write.
    drive(1, 1, 32'h300, 1, 1, 0, 24'h3, 0);
    expect_cycle("rdwr_hit", IDLE, R | AV | SD | UL, 32'h0);
    tick();

    // Stray mem_ack in IDLE is ignored.
    drive(0, 0, 32'h0, 0, 1, 1, 24'h0, 1);
    expect_cycle("idle_ack", IDLE, NONE, 32'h0);
    tick();
    drive(0, 0, 32'h0, 0, 0, 0, '0, 0);
    expect_cycle("idle_ack_after", IDLE, NONE, 32'h0);

    // Final report
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
